// File: rtl/led_panel_ctrl.sv
// led_panel_ctrl: lab-board sequencer that synchronizes the 4 switches and debounces the push-button.
// Each debounced button press steps the LED display mode PASS -> BLINK -> CHASE -> HOLD -> PASS.
// All LEDs are blanked while the button is held.
// Optional build macro LED_PANEL_CHASE_DIR_EN: in CHASE, sw[0] picks the rotate direction at each tick.
module led_panel_ctrl #(
  parameter int DEB_CYCLES  = 4,
  parameter int TICK_CYCLES = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] sw,
  input  logic       btn,
  output logic [3:0] led,
  output logic [1:0] mode
);
  localparam int DW = $clog2(DEB_CYCLES);
  localparam int TW = $clog2(TICK_CYCLES);

  typedef enum logic [1:0] {
    PASS  = 2'd0,
    BLINK = 2'd1,
    CHASE = 2'd2,
    HOLD  = 2'd3
  } mode_t;

  mode_t         r_mode;
  mode_t         w_mode_nxt;
  logic [3:0]    r_sw_meta;
  logic [3:0]    r_sw_s;
  logic          r_btn_meta;
  logic          r_btn_s;
  logic          r_btn_db;
  logic          r_btn_db_d;
  logic [DW-1:0] r_deb_cnt;
  logic [TW-1:0] r_tick_cnt;
  logic          r_phase;
  logic [3:0]    r_pattern;
  logic [3:0]    r_snap;
  logic [3:0]    r_led;
  logic          w_deb_diff;
  logic          w_deb_hit;
  logic          w_press;
  logic          w_tick;
  logic [3:0]    w_rot;
  logic [3:0]    w_led_nxt;

  assign w_deb_diff = r_btn_s != r_btn_db;
  assign w_deb_hit  = w_deb_diff && (r_deb_cnt == DW'(DEB_CYCLES - 1));
  assign w_press    = r_btn_db && !r_btn_db_d;
  assign w_tick     = r_tick_cnt == TW'(TICK_CYCLES - 1);

`ifdef LED_PANEL_CHASE_DIR_EN
  assign w_rot = r_sw_s[0] ? {r_pattern[2:0], r_pattern[3]} : {r_pattern[0], r_pattern[3:1]};
`else
  assign w_rot = {r_pattern[2:0], r_pattern[3]};
`endif

  assign led  = r_led;
  assign mode = r_mode;

  // two-flop synchronizers for the asynchronous switch and button pins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sw_meta  <= 4'b0000;
      r_sw_s     <= 4'b0000;
      r_btn_meta <= 1'b0;
      r_btn_s    <= 1'b0;
    end else begin
      r_sw_meta  <= sw;
      r_sw_s     <= r_sw_meta;
      r_btn_meta <= btn;
      r_btn_s    <= r_btn_meta;
    end
  end

  // debounce: the level is accepted only after DEB_CYCLES consecutive differing samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_btn_db   <= 1'b0;
      r_btn_db_d <= 1'b0;
      r_deb_cnt  <= '0;
    end else begin
      r_btn_db   <= w_deb_hit ? r_btn_s : r_btn_db;
      r_btn_db_d <= r_btn_db;
      r_deb_cnt  <= (w_deb_diff && !w_deb_hit) ? r_deb_cnt + DW'(1) : '0;
    end
  end

  // mode state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_mode <= PASS;
    else        r_mode <= w_mode_nxt;
  end

  // mode sequencing: advance one step per press, otherwise hold
  always_comb begin
    w_mode_nxt = r_mode;
    if (w_press)
      case (r_mode)
        PASS:    w_mode_nxt = BLINK;
        BLINK:   w_mode_nxt = CHASE;
        CHASE:   w_mode_nxt = HOLD;
        default: w_mode_nxt = PASS;
      endcase
  end

  // animation tick counter; a press restarts the period so every mode begins with a full step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_tick_cnt <= '0;
    else        r_tick_cnt <= (w_press || w_tick) ? '0 : r_tick_cnt + TW'(1);
  end

  // per-mode state: blink phase, chase pattern and hold snapshot; a press overrides a coincident tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase   <= 1'b0;
      r_pattern <= 4'b0001;
      r_snap    <= 4'b0000;
    end else if (w_press) begin
      r_phase   <= (w_mode_nxt == BLINK) ? 1'b1 : r_phase;
      r_pattern <= (w_mode_nxt == CHASE) ? 4'b0001 : r_pattern;
      r_snap    <= (w_mode_nxt == HOLD) ? r_sw_s : r_snap;
    end else if (w_tick) begin
      r_phase   <= (r_mode == BLINK) ? ~r_phase : r_phase;
      r_pattern <= (r_mode == CHASE) ? w_rot : r_pattern;
    end
  end

  // next LED value: blank while the button is held, otherwise the current mode's view
  always_comb begin
    w_led_nxt = 4'b0000;
    if (!r_btn_db)
      case (r_mode)
        PASS:    w_led_nxt = r_sw_s;
        BLINK:   w_led_nxt = r_phase ? r_sw_s : 4'b0000;
        CHASE:   w_led_nxt = r_pattern;
        default: w_led_nxt = r_snap;
      endcase
  end

  // registered LED drive
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_led <= 4'b0000;
    else        r_led <= w_led_nxt;
  end

endmodule

// File: doc/led_panel_ctrl.md
Name: led_panel_ctrl

Overview:
- Sequential controller for the board's 4 switches, 1 push-button and 4 LEDs.
- Synchronizes the switches, debounces the button, and uses button presses to cycle an LED display-mode FSM: PASS, BLINK, CHASE, HOLD.
- Retains the existing blanking rule: while the button is held, all LEDs are off.
- Sits between the board I/O pins and the LEDs; it is the top-level lab-board sequencer.

Parameters:
- DEB_CYCLES, 4, cycles a synchronized button level must stay stable before the debounced level changes (≥2).
- TICK_CYCLES, 3, clock cycles per animation step in BLINK/CHASE (≥2).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- sw  in  4  raw switch inputs, asynchronous.
- btn  in  1  raw push-button, active-high, asynchronous, bouncy.
- led  out  4  registered LED drive.
- mode  out  2  registered current mode: 0 = PASS, 1 = BLINK, 2 = CHASE, 3 = HOLD.

Behaviour:
- Reset (rst_n = 0, asynchronous) sets:
  - led = 0000, mode = 0 (PASS);
  - sync flops = 0, btn_db = 0, debounce counter = 0, tick counter = 0;
  - blink phase = 0, chase pattern = 0001, hold snapshot = 0000.
- Reset can be asserted mid-operation. Deassertion is synchronous to clk via existing board reset logic and is not handled here.
- Synchronizer: 2 flops each on sw and btn, giving sw_s and btn_s with 2-cycle lag.
- Debounce:
  - If btn_s != btn_db, the counter increments; when the counter reaches DEB_CYCLES-1 with btn_s still differing, btn_db takes btn_s and the counter clears.
  - If btn_s == btn_db, the counter clears. Any glitch shorter than DEB_CYCLES cycles is ignored.
- press: 1-cycle pulse on the btn_db 0->1 transition. The release edge generates nothing.
- Mode FSM, advancing only on press:
  - PASS -> BLINK -> CHASE -> HOLD -> PASS.
  - On the press that enters HOLD, the snapshot captures sw_s in the same cycle.
- Tick counter:
  - Counts 0..TICK_CYCLES-1 and asserts tick on the wrap cycle.
  - Clears to 0 on every press, so each mode starts with a full period.
- BLINK: phase toggles on each tick. Entering BLINK sets phase = 1.
- CHASE:
  - pattern rotates left on each tick (0001 -> 0010 -> 0100 -> 1000 -> 0001).
  - Entering CHASE loads 0001.
  - pattern always stays one-hot.
- Next-led function, registered so led changes 1 cycle after its inputs:
  - if btn_db = 1 -> 0000 (blank override, all modes);
  - PASS -> sw_s;
  - BLINK -> sw_s if phase = 1, else 0000;
  - CHASE -> pattern;
  - HOLD -> snapshot, with later sw changes ignored.
- Latency:
  - sw pin to led in PASS: 3 cycles.
  - btn pin to btn_db: 2 + DEB_CYCLES cycles of stable level.
  - mode output updates the cycle after press.
- Simultaneous tick and press: press wins. The new mode's initial state is loaded and the tick is discarded.
- All counters are width ceil(log2(param)) and are never allowed to exceed param-1.

Optional Feature:
- Macro LED_PANEL_CHASE_DIR_EN.
- Defined:
  - In CHASE, sw_s[0] selects the direction on each tick: 1 = rotate left, 0 = rotate right (0001 -> 1000 -> 0100 -> 0010 -> 0001).
  - Direction is sampled at tick time.
- Undefined: CHASE always rotates left and sw has no effect in CHASE.
- All other behaviour is identical in both builds.

Test Plan:
- Reset then PASS: rst_n low 2 cycles, release, sw = 1010 -> led = 0000 and mode = 0 during reset; led = 1010 exactly 3 cycles after sw applied.
- Debounce/blank: btn pulses high for 2 cycles, 3 times, then stays high 10 cycles -> glitches leave mode = 0 and led unchanged; after 2+4 stable cycles led = 0000 and mode = 1 the next cycle.
- BLINK: mode 1, sw = 0110, btn released -> led alternates 0110/0000 every 3 cycles, starting with 0110 after release debounce.
- CHASE: press into mode 2 -> led = 0001, 0010, 0100, 1000, 0001 at 3-cycle steps; with LED_PANEL_CHASE_DIR_EN and sw[0] = 0 -> 0001, 1000, 0100.
- HOLD: sw = 1100 at the press entering mode 3, then sw = 0011 -> led stays 1100; next press -> mode = 0 and led = 0011.
- Async reset mid-CHASE: rst_n dropped between clock edges -> led = 0000 and mode = 0 immediately, with no clock edge required; after release pattern restarts at 0001 on the next CHASE entry.
